// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core widths and writeback arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_HOLD  = 2'd1,
    WB_FORCE = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Shares the regfile write port between the ALU and a buffered
//               MDU result; ALU has priority, starvation forces a 1-cycle stall.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int RADDR_W  = core_pkg::RADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               alu_we5,
  input  logic [RADDR_W-1:0] alu_rd5,
  input  logic [XLEN-1:0]    alu_res5,
  input  logic               mdu_valid,
  input  logic [RADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]    mdu_res,
  output logic               mdu_ready,
  output logic               stall,
  output logic               we6,
  output logic [RADDR_W-1:0] rd6,
  output logic [XLEN-1:0]    wb_data6
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_WAIT - 1);

  wb_state_t          r_state;
  wb_state_t          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RADDR_W-1:0] r_buf_rd;
  logic [XLEN-1:0]    r_buf_data;

  logic w_alu_eff;
  logic w_hs;
  logic w_wr;
  logic w_sel_buf;
  logic w_load;

  assign stall     = (r_state == WB_FORCE);
  assign mdu_ready = (r_state == WB_IDLE);
  assign w_alu_eff = alu_we5 && (alu_rd5 != '0) && !stall;
  assign w_hs      = mdu_valid && mdu_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_sel_buf   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      WB_IDLE: begin
        w_wr = w_alu_eff;
        // A result aimed at x0 is consumed but never buffered.
        if (w_hs && (mdu_rd != '0)) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WB_HOLD;
        end
      end
      WB_HOLD: begin
        w_wr = 1'b1;
        if (!w_alu_eff) begin
          w_sel_buf   = 1'b1;
          w_state_nxt = WB_IDLE;
        end else if (alu_rd5 == r_buf_rd) begin
          w_state_nxt = WB_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = WB_FORCE;
          end
        end
      end
      WB_FORCE: begin
        w_wr        = 1'b1;
        w_sel_buf   = 1'b1;
        w_state_nxt = WB_IDLE;
      end
      default: begin
        w_state_nxt = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state    <= WB_IDLE;
      r_cnt      <= '0;
      r_buf_rd   <= '0;
      r_buf_data <= '0;
      we6        <= 1'b0;
      rd6        <= '0;
      wb_data6   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_buf_rd   <= mdu_rd;
        r_buf_data <= mdu_res;
      end
      we6      <= w_wr;
      rd6      <= !w_wr ? '0 : (w_sel_buf ? r_buf_rd : alu_rd5);
      wb_data6 <= !w_wr ? '0 : (w_sel_buf ? r_buf_data : alu_res5);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed and randomized self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import core_pkg::*;

  localparam int MAX_WAIT = 4;

  logic               clk = 1'b0;
  logic               nrst;
  logic               alu_we5;
  logic [RADDR_W-1:0] alu_rd5;
  logic [XLEN-1:0]    alu_res5;
  logic               mdu_valid;
  logic [RADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]    mdu_res;
  logic               mdu_ready;
  logic               stall;
  logic               we6;
  logic [RADDR_W-1:0] rd6;
  logic [XLEN-1:0]    wb_data6;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending MDU result plus the number of ALU wins it has suffered.
  logic               m_held  = 1'b0;
  logic               m_force = 1'b0;
  int                 m_wins  = 0;
  logic [RADDR_W-1:0] m_rd    = '0;
  logic [XLEN-1:0]    m_data  = '0;
  logic               e_we    = 1'b0;
  logic [RADDR_W-1:0] e_rd    = '0;
  logic [XLEN-1:0]    e_data  = '0;

  wb_arbiter #(.XLEN(XLEN), .RADDR_W(RADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .nrst(nrst),
    .alu_we5(alu_we5), .alu_rd5(alu_rd5), .alu_res5(alu_res5),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_res(mdu_res),
    .mdu_ready(mdu_ready), .stall(stall),
    .we6(we6), .rd6(rd6), .wb_data6(wb_data6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic               wr;
    logic [RADDR_W-1:0] wrd;
    logic [XLEN-1:0]    wdat;
    logic               alu_ok;
    @(negedge clk);
    chk("stall", 32'(stall), 32'(m_force));
    chk("mdu_ready", 32'(mdu_ready), 32'(!m_held));
    chk("we6", 32'(we6), 32'(e_we));
    chk("rd6", 32'(rd6), 32'(e_rd));
    chk("wb_data6", wb_data6, e_data);
    wr = 1'b0; wrd = '0; wdat = '0;
    alu_ok = alu_we5 && (alu_rd5 != 0) && !m_force;
    if (nrst) begin
      m_held = 1'b0; m_force = 1'b0; m_wins = 0;
    end else if (m_force) begin
      wr = 1'b1; wrd = m_rd; wdat = m_data;
      m_held = 1'b0; m_force = 1'b0;
    end else if (m_held) begin
      wr = 1'b1;
      if (!alu_ok) begin
        wrd = m_rd; wdat = m_data; m_held = 1'b0;
      end else begin
        wrd = alu_rd5; wdat = alu_res5;
        if (alu_rd5 == m_rd) begin
          m_held = 1'b0;
        end else begin
          m_wins++;
          if (m_wins == MAX_WAIT) m_force = 1'b1;
        end
      end
    end else begin
      if (alu_ok) begin
        wr = 1'b1; wrd = alu_rd5; wdat = alu_res5;
      end
      if (mdu_valid && (mdu_rd != 0)) begin
        m_held = 1'b1; m_wins = 0; m_rd = mdu_rd; m_data = mdu_res;
      end
    end
    e_we = wr; e_rd = wrd; e_data = wdat;
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic we, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] res);
    alu_we5 = we; alu_rd5 = rd; alu_res5 = res;
  endtask

  task automatic mdu(input logic v, input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] res);
    mdu_valid = v; mdu_rd = rd; mdu_res = res;
  endtask

  initial begin
    nrst = 1'b1;
    alu(1'b0, '0, '0);
    mdu(1'b0, '0, '0);
    @(posedge clk); #1;
    step();
    step();
    chk("reset_we6", 32'(we6), 32'd0);
    chk("reset_rd6", 32'(rd6), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_ready", 32'(mdu_ready), 32'd1);
    nrst = 1'b0;

    // ALU write, then x0 suppressed
    alu(1'b1, 5'd3, 32'h55);
    step();
    chk("alu_we6", 32'(we6), 32'd1);
    chk("alu_rd6", 32'(rd6), 32'd3);
    chk("alu_data", wb_data6, 32'h55);
    alu(1'b1, 5'd0, 32'h66);
    step();
    chk("x0_we6", 32'(we6), 32'd0);
    alu(1'b0, '0, '0);

    // Lone MDU result drains two cycles after handshake
    mdu(1'b1, 5'd7, 32'hDEAD);
    step();
    chk("mdu_busy", 32'(mdu_ready), 32'd0);
    mdu(1'b0, '0, '0);
    step();
    chk("mdu_we6", 32'(we6), 32'd1);
    chk("mdu_rd6", 32'(rd6), 32'd7);
    chk("mdu_data", wb_data6, 32'hDEAD);
    chk("mdu_ready_back", 32'(mdu_ready), 32'd1);

    // Starvation: four ALU wins, then a forced stall drains the buffer
    mdu(1'b1, 5'd7, 32'hBEEF);
    step();
    mdu(1'b0, '0, '0);
    for (int i = 1; i <= 4; i++) begin
      alu(1'b1, 5'(i), 32'(i * 16));
      step();
      chk("starve_rd6", 32'(rd6), 32'(i));
    end
    chk("force_stall", 32'(stall), 32'd1);
    alu(1'b1, 5'd5, 32'h500);
    step();
    chk("force_rd6", 32'(rd6), 32'd7);
    chk("force_data", wb_data6, 32'hBEEF);
    chk("force_release", 32'(stall), 32'd0);
    step();
    chk("held_alu_rd6", 32'(rd6), 32'd5);
    chk("held_alu_data", wb_data6, 32'h500);
    alu(1'b0, '0, '0);

    // Same destination: younger ALU write wins, buffer dropped
    mdu(1'b1, 5'd9, 32'h99);
    step();
    mdu(1'b0, '0, '0);
    alu(1'b1, 5'd9, 32'h11);
    step();
    chk("same_rd6", 32'(rd6), 32'd9);
    chk("same_data", wb_data6, 32'h11);
    chk("same_ready", 32'(mdu_ready), 32'd1);
    alu(1'b0, '0, '0);
    step();
    chk("dropped_we6", 32'(we6), 32'd0);

    // Reset while holding discards the buffer; x0 MDU result is swallowed
    mdu(1'b1, 5'd12, 32'hC0);
    step();
    mdu(1'b0, '0, '0);
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    chk("rst_hold_ready", 32'(mdu_ready), 32'd1);
    step();
    chk("rst_hold_we6", 32'(we6), 32'd0);
    mdu(1'b1, 5'd0, 32'hAB);
    step();
    chk("x0_mdu_ready", 32'(mdu_ready), 32'd1);
    mdu(1'b0, '0, '0);
    step();
    chk("x0_mdu_we6", 32'(we6), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      nrst = ($urandom_range(0, 99) == 0);
      if (!m_force)
        alu($urandom_range(0, 3) != 0, RADDR_W'($urandom_range(0, 11)), $urandom);
      if (!(mdu_valid && m_held))
        mdu($urandom_range(0, 2) == 0, RADDR_W'($urandom_range(0, 11)), $urandom);
      step();
    end
    nrst = 1'b0;
    alu(1'b0, '0, '0);
    mdu(1'b0, '0, '0);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
